// File: rtl/dmem_mmio_ctrl_pkg.sv
// Shared constants for the data-memory / MMIO controller: write-enable codes,
// MMIO register offsets, status bit positions and read-source select.
package dmem_mmio_ctrl_pkg;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_BYTE = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b011;
  localparam logic [2:0] WE_WORD = 3'b111;

  localparam logic [7:0] OFF_MTIME_LO = 8'h00;
  localparam logic [7:0] OFF_MTIME_HI = 8'h04;
  localparam logic [7:0] OFF_CMP_LO   = 8'h08;
  localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
  localparam logic [7:0] OFF_TX       = 8'h10;
  localparam logic [7:0] OFF_STATUS   = 8'h14;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_CNT_LSB = 2;
  localparam int STAT_OVF     = 5;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_MMIO
  } rd_src_e;

  // Byte-lane mask for a write; zero means the write is dropped.
  function automatic logic [3:0] lane_mask(input logic [2:0] we, input logic [1:0] off);
    case (we)
      WE_BYTE: return 4'b0001 << off;
      WE_HALF: return off[0] ? 4'b0000 : (off[1] ? 4'b1100 : 4'b0011);
      WE_WORD: return (off == 2'b00) ? 4'b1111 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_mmio_ctrl_tx_fifo.sv
// Circular TX FIFO; overflow policy lives in the parent, this block simply
// refuses a push when full unless a pop frees the slot in the same cycle.
module dmem_mmio_ctrl_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory subsystem: byte-writable RAM plus an MMIO page with a 64-bit
// machine timer/compare interrupt and a UART TX FIFO. Reads have 1-cycle latency.
module dmem_mmio_ctrl
  import dmem_mmio_ctrl_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter int               RAM_WORDS  = 1024,
  parameter logic [XLEN-1:0]  MMIO_BASE  = 32'h8000_0000,
  parameter int               TIMER_DIV  = 1,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] data_mem_addr,
  input  logic [XLEN-1:0] data_mem_wdata,
  input  logic [2:0]      data_mem_we,
  output logic [XLEN-1:0] data_mem_out,
  output logic            timer_irq,
  output logic [7:0]      uart_tx_data,
  output logic            uart_tx_valid,
  input  logic            uart_tx_ready
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int PRESC_W = $clog2(TIMER_DIV) + 1;

  logic [XLEN-1:0]   ram_q [RAM_WORDS];
  logic [XLEN-1:0]   ram_rdata_q;
  logic [XLEN-1:0]   mmio_rdata_q, mmio_rdata_d;
  rd_src_e           src_q, src_d;

  logic              we_prev_q;
  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       cmp_q, cmp_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic              irq_q;
  logic              ovf_q, ovf_d;

  logic              commit;
  logic              ram_hit, mmio_hit;
  logic [7:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic [3:0]        be;
  logic [XLEN-1:0]   wlanes;
  logic              ram_wr, mmio_wr;
  logic              wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_status;
  logic              push, pop, tick;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        fifo_head;
  logic [XLEN-1:0]   status;

  // A held we commits only on its first cycle; a cycle in reset never commits.
  assign commit   = (data_mem_we != WE_NONE) && !we_prev_q && !rst;
  assign ram_hit  = data_mem_addr < XLEN'(RAM_WORDS * 4);
  assign mmio_hit = data_mem_addr[XLEN-1:8] == MMIO_BASE[XLEN-1:8];
  assign mmio_off = data_mem_addr[7:0];
  assign ram_idx  = data_mem_addr[RAM_AW+1:2];
  assign be       = lane_mask(data_mem_we, data_mem_addr[1:0]);

  assign ram_wr  = commit && ram_hit;
  assign mmio_wr = commit && mmio_hit && (data_mem_we == WE_WORD) && (data_mem_addr[1:0] == 2'b00);

  assign wr_mtime_lo = mmio_wr && (mmio_off == OFF_MTIME_LO);
  assign wr_mtime_hi = mmio_wr && (mmio_off == OFF_MTIME_HI);
  assign wr_cmp_lo   = mmio_wr && (mmio_off == OFF_CMP_LO);
  assign wr_cmp_hi   = mmio_wr && (mmio_off == OFF_CMP_HI);
  assign wr_status   = mmio_wr && (mmio_off == OFF_STATUS);
  assign push        = mmio_wr && (mmio_off == OFF_TX);
  assign pop         = uart_tx_valid && uart_tx_ready;

  always_comb begin
    wlanes = data_mem_wdata;
    case (data_mem_we)
      WE_BYTE: wlanes = {4{data_mem_wdata[7:0]}};
      WE_HALF: wlanes = {2{data_mem_wdata[15:0]}};
      default: wlanes = data_mem_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_wr && be[i]) ram_q[ram_idx][8*i +: 8] <= wlanes[8*i +: 8];
    end
    ram_rdata_q <= ram_q[ram_idx];
  end

  assign tick = (presc_q == PRESC_W'(TIMER_DIV - 1));

  always_comb begin
    presc_d = presc_q;
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    if (wr_mtime_lo || wr_mtime_hi) begin
      presc_d = '0;
      if (wr_mtime_lo) mtime_d[31:0]  = data_mem_wdata[31:0];
      if (wr_mtime_hi) mtime_d[63:32] = data_mem_wdata[31:0];
    end else if (tick) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
    if (wr_cmp_lo) cmp_d[31:0]  = data_mem_wdata[31:0];
    if (wr_cmp_hi) cmp_d[63:32] = data_mem_wdata[31:0];
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_status) ovf_d = 1'b0;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    status                          = '0;
    status[STAT_FULL]               = fifo_full;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_CNT_LSB +: CNT_W]   = fifo_count;
    status[STAT_OVF]                = ovf_q;
  end

  always_comb begin
    mmio_rdata_d = '0;
    case (mmio_off)
      OFF_MTIME_LO: mmio_rdata_d = mtime_q[31:0];
      OFF_MTIME_HI: mmio_rdata_d = mtime_q[63:32];
      OFF_CMP_LO:   mmio_rdata_d = cmp_q[31:0];
      OFF_CMP_HI:   mmio_rdata_d = cmp_q[63:32];
      OFF_STATUS:   mmio_rdata_d = status;
      default:      mmio_rdata_d = '0;
    endcase
    src_d = ram_hit ? SRC_RAM : (mmio_hit ? SRC_MMIO : SRC_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_prev_q    <= 1'b0;
      mtime_q      <= '0;
      cmp_q        <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc_q      <= '0;
      irq_q        <= 1'b0;
      ovf_q        <= 1'b0;
      src_q        <= SRC_NONE;
      mmio_rdata_q <= '0;
    end else begin
      we_prev_q    <= (data_mem_we != WE_NONE);
      mtime_q      <= mtime_d;
      cmp_q        <= cmp_d;
      presc_q      <= presc_d;
      irq_q        <= (mtime_q >= cmp_q);
      ovf_q        <= ovf_d;
      src_q        <= src_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  always_comb begin
    case (src_q)
      SRC_RAM:  data_mem_out = ram_rdata_q;
      SRC_MMIO: data_mem_out = mmio_rdata_q;
      default:  data_mem_out = '0;
    endcase
  end

  dmem_mmio_ctrl_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (data_mem_wdata[7:0]),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign timer_irq     = irq_q;
  assign uart_tx_data  = fifo_head;
  assign uart_tx_valid = !fifo_empty;

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Directed bench for dmem_mmio_ctrl: a vector table for RAM/decode behaviour
// plus hand sequences for commit edge detection, FIFO, timer and reset.
module tb_dmem_mmio_ctrl;

  localparam logic [31:0] MB = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [2:0]  we;
  logic [31:0] dout;
  logic        irq, valid, ready;
  logic [7:0]  txd;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] waddr;
    logic [2:0]  we;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  dmem_mmio_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .data_mem_addr  (addr),
    .data_mem_wdata (wdata),
    .data_mem_we    (we),
    .data_mem_out   (dout),
    .timer_irq      (irq),
    .uart_tx_data   (txd),
    .uart_tx_valid  (valid),
    .uart_tx_ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = w;
    @(negedge clk);
    we = 3'b000;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; we = 3'b000;
    @(negedge clk);
    d = dout;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] s;
    do_read(MB + 32'h14, s);
    check(name, s, exp);
  endtask

  initial begin
    logic [7:0] exp_bytes [4];

    vecs[0]  = '{32'h0000_0010, 3'b111, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1]  = '{32'h0000_0012, 3'b001, 32'h0000_0055, 32'h0000_0010, 32'hDE55_BEEF};
    vecs[2]  = '{32'h0000_0020, 3'b111, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678};
    vecs[3]  = '{32'h0000_0021, 3'b011, 32'h0000_AAAA, 32'h0000_0020, 32'h1234_5678};
    vecs[4]  = '{32'h0000_0022, 3'b011, 32'h0000_CAFE, 32'h0000_0020, 32'hCAFE_5678};
    vecs[5]  = '{32'h0000_0020, 3'b011, 32'h0000_1111, 32'h0000_0020, 32'hCAFE_1111};
    vecs[6]  = '{32'h0000_0023, 3'b001, 32'h0000_00FF, 32'h0000_0020, 32'hFFFE_1111};
    vecs[7]  = '{32'h0000_0024, 3'b111, 32'h0000_0000, 32'h0000_0024, 32'h0000_0000};
    vecs[8]  = '{32'h0000_0026, 3'b111, 32'hFFFF_FFFF, 32'h0000_0024, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0024, 3'b010, 32'hFFFF_FFFF, 32'h0000_0024, 32'h0000_0000};
    vecs[10] = '{32'h0000_0024, 3'b101, 32'hFFFF_FFFF, 32'h0000_0024, 32'h0000_0000};
    vecs[11] = '{32'h0000_0FFC, 3'b111, 32'hA5A5_A5A5, 32'h0000_0FFC, 32'hA5A5_A5A5};
    vecs[12] = '{32'h0000_0000, 3'b111, 32'h1111_1111, 32'h0000_0000, 32'h1111_1111};
    vecs[13] = '{32'h0000_1000, 3'b111, 32'h9999_9999, 32'h0000_0000, 32'h1111_1111};
    vecs[14] = '{32'h0000_1000, 3'b000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
    vecs[15] = '{MB + 32'h08,   3'b001, 32'h0000_0000, MB + 32'h08,   32'hFFFF_FFFF};
    vecs[16] = '{MB + 32'h0C,   3'b011, 32'h0000_0000, MB + 32'h0C,   32'hFFFF_FFFF};
    vecs[17] = '{MB + 32'h10,   3'b000, 32'h0000_0000, MB + 32'h10,   32'h0000_0000};
    vecs[18] = '{MB + 32'h100,  3'b000, 32'h0000_0000, MB + 32'h100,  32'h0000_0000};
    vecs[19] = '{32'h0000_0000, 3'b000, 32'h0000_0000, MB + 32'h14,   32'h0000_0002};

    rst = 1'b1; addr = '0; wdata = '0; we = 3'b000; ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_valid", {31'b0, valid}, 32'h0);
    check("rst_txd", {24'b0, txd}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].we != 3'b000) do_write(vecs[i].waddr, vecs[i].we, vecs[i].wdata);
      do_read(vecs[i].raddr, rdata);
      check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end

    // we held for 5 cycles must push once
    @(negedge clk);
    addr = MB + 32'h10; wdata = 32'h41; we = 3'b111;
    repeat (5) @(negedge clk);
    we = 3'b000;
    check_status("held_we_status", 32'h04);
    check("held_we_head", {24'b0, txd}, 32'h41);
    @(negedge clk) ready = 1'b1;
    @(negedge clk) ready = 1'b0;
    check("held_we_drained", {31'b0, valid}, 32'h0);

    for (int i = 1; i <= 5; i++) do_write(MB + 32'h10, 3'b111, 32'(i));
    check_status("ovf_status", 32'h31);
    @(negedge clk) ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d", i), {23'b0, valid, txd}, {23'b0, 1'b1, 8'(i)});
      @(negedge clk);
    end
    check("drain_done_valid", {31'b0, valid}, 32'h0);
    ready = 1'b0;
    check_status("empty_ovf_status", 32'h22);
    do_write(MB + 32'h14, 3'b111, 32'h0);
    check_status("ovf_cleared", 32'h02);

    for (int i = 0; i < 4; i++) do_write(MB + 32'h10, 3'b111, 32'hA1 + 32'(i));
    @(negedge clk);
    check("full_head", {24'b0, txd}, 32'hA1);
    addr = MB + 32'h10; wdata = 32'h66; we = 3'b111; ready = 1'b1;
    @(negedge clk);
    we = 3'b000; ready = 1'b0;
    check_status("pushpop_full_status", 32'h11);
    exp_bytes[0] = 8'hA2; exp_bytes[1] = 8'hA3; exp_bytes[2] = 8'hA4; exp_bytes[3] = 8'h66;
    @(negedge clk) ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pushpop_drain%0d", i), {23'b0, valid, txd}, {23'b0, 1'b1, exp_bytes[i]});
      @(negedge clk);
    end
    ready = 1'b0;
    check("pushpop_empty", {31'b0, valid}, 32'h0);

    // timer compare: clear mtime last so the rise time is exact
    do_write(MB + 32'h0C, 3'b111, 32'h0);
    do_write(MB + 32'h08, 3'b111, 32'd10);
    do_write(MB + 32'h04, 3'b111, 32'h0);
    do_write(MB + 32'h00, 3'b111, 32'h0);
    @(negedge clk);
    check("irq_after_clear", {31'b0, irq}, 32'h0);
    repeat (9) @(negedge clk);
    check("irq_before_cmp", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_at_cmp", {31'b0, irq}, 32'h1);
    do_write(MB + 32'h0C, 3'b111, 32'h1);
    @(negedge clk);
    check("irq_after_cmp_hi", {31'b0, irq}, 32'h0);

    do_write(MB + 32'h04, 3'b111, 32'h0);
    @(negedge clk);
    addr = MB + 32'h00; wdata = 32'hFFFF_FFFF; we = 3'b111;
    @(negedge clk);
    we = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("mtime_wrap_lo", dout, 32'h0);
    addr = MB + 32'h04;
    @(negedge clk);
    check("mtime_wrap_hi", dout, 32'h1);

    for (int i = 0; i < 3; i++) do_write(MB + 32'h10, 3'b111, 32'hC0 + 32'(i));
    repeat (10) @(negedge clk);
    check("irq_before_reset", {31'b0, irq}, 32'h1);
    ready = 1'b1;
    @(negedge clk);
    check("mid_drain_valid", {23'b0, valid, txd}, {23'b0, 1'b1, 8'hC1});
    rst = 1'b1; ready = 1'b0;
    addr = MB + 32'h10; wdata = 32'h77; we = 3'b111;
    @(negedge clk);
    check("reset_valid", {31'b0, valid}, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    check("reset_txd", {24'b0, txd}, 32'h0);
    check("reset_dout", dout, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    we = 3'b000;
    check("held_we_after_reset", {23'b0, valid, txd}, {23'b0, 1'b1, 8'h77});
    check_status("post_reset_status", 32'h04);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
